// File: rtl/mips_core_pkg.sv
// Shared core types for the data-cache port arbiter.
// Supplies default ADDR_WIDTH / DATA_WIDTH when the build does not set them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mips_core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } dc_arb_state_e;

  typedef enum logic {
    OWN_LOAD,
    OWN_STORE
  } dc_owner_e;

endpackage

// File: rtl/dcache_arb_select.sv
// Priority pick between load and store requesters for the dcache port.
// DCACHE_ARB_STARVE_GUARD_EN adds the store-starvation rule.
module dcache_arb_select
`ifdef DCACHE_ARB_STARVE_GUARD_EN
#(
  parameter int CNT_W        = 4,
  parameter int STARVE_LIMIT = 8
)
`endif
(
`ifdef DCACHE_ARB_STARVE_GUARD_EN
  input  logic [CNT_W-1:0] starve_cnt,
`endif
  input  logic             ld_valid,
  input  logic             st_valid,
  input  logic             st_full,
  input  logic             flush,
  output logic             grant_load,
  output logic             grant_store
);

  logic st_urgent;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
  assign st_urgent = st_valid &&
    (st_full || (starve_cnt == CNT_W'(STARVE_LIMIT)));
`else
  assign st_urgent = st_valid && st_full;
`endif

  always_comb begin
    grant_load  = 1'b0;
    grant_store = 1'b0;
    if (st_urgent) begin
      grant_store = 1'b1;
    end else if (ld_valid && !flush) begin
      grant_load = 1'b1;
    end else if (st_valid) begin
      grant_store = 1'b1;
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Single dcache port shared by speculative loads and committed stores.
// DCACHE_ARB_STARVE_GUARD_EN enables the store-starvation counter.
module dcache_port_arbiter
  import mips_core_pkg::*;
#(
  parameter int ADDR_W       = `ADDR_WIDTH,
  parameter int DATA_W       = `DATA_WIDTH,
  parameter int LQ_IDX_W     = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_req_valid,
  output logic                ld_req_ready,
  input  logic [ADDR_W-1:0]   ld_req_addr,
  input  logic [LQ_IDX_W-1:0] ld_req_idx,
  input  logic                st_req_valid,
  output logic                st_req_ready,
  input  logic [ADDR_W-1:0]   st_req_addr,
  input  logic [DATA_W-1:0]   st_req_data,
  input  logic                st_buf_full,
  input  logic                flush,
  output logic                dc_req_valid,
  input  logic                dc_req_ready,
  output logic                dc_req_we,
  output logic [ADDR_W-1:0]   dc_req_addr,
  output logic [DATA_W-1:0]   dc_req_data,
  input  logic                dc_resp_valid,
  input  logic [DATA_W-1:0]   dc_resp_data,
  output logic                ld_resp_valid,
  output logic [LQ_IDX_W-1:0] ld_resp_idx,
  output logic [DATA_W-1:0]   ld_resp_data,
  output logic                st_done,
  output logic                busy
);

  dc_arb_state_e       state;
  dc_arb_state_e       state_nxt;
  dc_owner_e           owner;
  logic                squash;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [LQ_IDX_W-1:0] idx_q;
  logic                grant_load;
  logic                grant_store;
  logic                in_idle;
  logic                in_issue;
  logic                in_wait;
  logic                is_load;
  logic                drop;

  assign in_idle  = (state == IDLE);
  assign in_issue = (state == ISSUE);
  assign in_wait  = (state == WAIT);
  assign is_load  = (owner == OWN_LOAD);

  // A flushed load the cache has not yet taken is simply abandoned
  assign drop = in_issue && is_load && flush && !dc_req_ready;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (in_idle) begin
      if (grant_store || !st_req_valid) begin
        starve_cnt <= '0;
      end else if (grant_load &&
                   starve_cnt != CNT_W'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  dcache_arb_select #(
    .CNT_W        (CNT_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_select (
    .starve_cnt  (starve_cnt),
    .ld_valid    (ld_req_valid),
    .st_valid    (st_req_valid),
    .st_full     (st_buf_full),
    .flush       (flush),
    .grant_load  (grant_load),
    .grant_store (grant_store)
  );
`else
  logic unused_limit;
  assign unused_limit = (STARVE_LIMIT > 0);

  dcache_arb_select u_select (
    .ld_valid    (ld_req_valid),
    .st_valid    (st_req_valid),
    .st_full     (st_buf_full),
    .flush       (flush),
    .grant_load  (grant_load),
    .grant_store (grant_store)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_load || grant_store) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (drop) begin
          state_nxt = IDLE;
        end else if (dc_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (dc_resp_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_req_ready  = in_idle && grant_load;
    st_req_ready  = in_idle && grant_store;
    dc_req_valid  = in_issue;
    ld_resp_valid = in_wait && is_load && dc_resp_valid &&
                    !squash && !flush;
    st_done       = in_wait && !is_load && dc_resp_valid;
    busy          = !in_idle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner  <= OWN_LOAD;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      idx_q  <= '0;
    end else if (in_idle && grant_store) begin
      owner  <= OWN_STORE;
      we_q   <= 1'b1;
      addr_q <= st_req_addr;
      data_q <= st_req_data;
    end else if (in_idle && grant_load) begin
      owner  <= OWN_LOAD;
      we_q   <= 1'b0;
      addr_q <= ld_req_addr;
      idx_q  <= ld_req_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      squash <= 1'b0;
    end else if (state_nxt == IDLE) begin
      squash <= 1'b0;
    end else if (is_load && flush &&
                 (in_wait || (in_issue && dc_req_ready))) begin
      squash <= 1'b1;
    end
  end

  assign dc_req_we    = we_q;
  assign dc_req_addr  = addr_q;
  assign dc_req_data  = data_q;
  assign ld_resp_idx  = idx_q;
  assign ld_resp_data = dc_resp_data;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: directed scenarios, then random traffic.
// Expected outputs come from a transaction-level model of the arbiter.
module tb_dcache_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IW  = 3;
  localparam int LIM = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_req_valid, ld_req_ready;
  logic [AW-1:0] ld_req_addr;
  logic [IW-1:0] ld_req_idx;
  logic          st_req_valid, st_req_ready;
  logic [AW-1:0] st_req_addr;
  logic [DW-1:0] st_req_data;
  logic          st_buf_full, flush;
  logic          dc_req_valid, dc_req_ready, dc_req_we;
  logic [AW-1:0] dc_req_addr;
  logic [DW-1:0] dc_req_data;
  logic          dc_resp_valid;
  logic [DW-1:0] dc_resp_data;
  logic          ld_resp_valid;
  logic [IW-1:0] ld_resp_idx;
  logic [DW-1:0] ld_resp_data;
  logic          st_done, busy;

  always #5 clk = ~clk;

  dcache_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .LQ_IDX_W     (IW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld_req_valid  (ld_req_valid),
    .ld_req_ready  (ld_req_ready),
    .ld_req_addr   (ld_req_addr),
    .ld_req_idx    (ld_req_idx),
    .st_req_valid  (st_req_valid),
    .st_req_ready  (st_req_ready),
    .st_req_addr   (st_req_addr),
    .st_req_data   (st_req_data),
    .st_buf_full   (st_buf_full),
    .flush         (flush),
    .dc_req_valid  (dc_req_valid),
    .dc_req_ready  (dc_req_ready),
    .dc_req_we     (dc_req_we),
    .dc_req_addr   (dc_req_addr),
    .dc_req_data   (dc_req_data),
    .dc_resp_valid (dc_resp_valid),
    .dc_resp_data  (dc_resp_data),
    .ld_resp_valid (ld_resp_valid),
    .ld_resp_idx   (ld_resp_idx),
    .ld_resp_data  (ld_resp_data),
    .st_done       (st_done),
    .busy          (busy)
  );

  int total = 0;
  int bad   = 0;

  // One outstanding access, tracked as a transaction record
  typedef struct {
    bit            v;
    bit            store;
    bit            issued;
    bit            squashed;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
  } txn_t;

  txn_t cur;
  int   starve;
  int   dut_grants[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner();
    if (st_req_valid && st_buf_full) return 2;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
    if (starve == LIM && st_req_valid) return 2;
`endif
    if (ld_req_valid && !flush) return 1;
    if (st_req_valid) return 2;
    return 0;
  endfunction

  task automatic idle_in();
    ld_req_valid  = 1'b0;
    ld_req_addr   = '0;
    ld_req_idx    = '0;
    st_req_valid  = 1'b0;
    st_req_addr   = '0;
    st_req_data   = '0;
    st_buf_full   = 1'b0;
    flush         = 1'b0;
    dc_req_ready  = 1'b0;
    dc_resp_valid = 1'b0;
    dc_resp_data  = '0;
  endtask

  task automatic model_reset();
    cur    = '{default: '0};
    starve = 0;
  endtask

  task automatic model_update(input int w);
    if (!cur.v) begin
      if (w != 0) begin
        cur.v        = 1'b1;
        cur.store    = (w == 2);
        cur.issued   = 1'b0;
        cur.squashed = 1'b0;
        cur.addr     = (w == 2) ? st_req_addr : ld_req_addr;
        cur.data     = st_req_data;
        cur.idx      = ld_req_idx;
      end
      if (w == 2 || !st_req_valid) starve = 0;
      else if (w == 1 && starve < LIM) starve++;
    end else if (!cur.issued) begin
      if (!cur.store && flush && !dc_req_ready) begin
        cur.v = 1'b0;
      end else if (dc_req_ready) begin
        cur.issued   = 1'b1;
        cur.squashed = !cur.store && flush;
      end
    end else begin
      if (dc_resp_valid) cur.v = 1'b0;
      else if (!cur.store && flush) cur.squashed = 1'b1;
    end
  endtask

  // Inputs are set just after a rising edge; outputs sampled mid-cycle
  task automatic step();
    int w;
    bit e_ldr;
    bit e_str;
    bit e_req;
    bit e_ldresp;
    bit e_stdone;
    #4;
    w        = cur.v ? 0 : winner();
    e_ldr    = (w == 1);
    e_str    = (w == 2);
    e_req    = cur.v && !cur.issued;
    e_ldresp = cur.v && cur.issued && !cur.store && dc_resp_valid &&
               !cur.squashed && !flush;
    e_stdone = cur.v && cur.issued && cur.store && dc_resp_valid;
    chk("ld_req_ready", ld_req_ready, e_ldr);
    chk("st_req_ready", st_req_ready, e_str);
    chk("dc_req_valid", dc_req_valid, e_req);
    chk("ld_resp_valid", ld_resp_valid, e_ldresp);
    chk("st_done", st_done, e_stdone);
    chk("busy", busy, cur.v);
    if (e_req) begin
      chk("dc_req_addr", dc_req_addr, cur.addr);
      chk("dc_req_we", dc_req_we, cur.store);
      if (cur.store) chk("dc_req_data", dc_req_data, cur.data);
    end
    if (e_ldresp) begin
      chk("ld_resp_idx", ld_resp_idx, cur.idx);
      chk("ld_resp_data", ld_resp_data, dc_resp_data);
    end
    if (ld_req_ready) dut_grants.push_back(1);
    if (st_req_ready) dut_grants.push_back(2);
    @(posedge clk);
    model_update(w);
    #1;
  endtask

  task automatic drain();
    idle_in();
    dc_req_ready  = 1'b1;
    dc_resp_valid = 1'b1;
    for (int i = 0; i < 8 && cur.v; i++) step();
    idle_in();
    step();
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_dc_req_valid"}, dc_req_valid, 1'b0);
    chk({tag, "_dc_req_addr"}, dc_req_addr, '0);
    chk({tag, "_dc_req_data"}, dc_req_data, '0);
    chk({tag, "_dc_req_we"}, dc_req_we, 1'b0);
    chk({tag, "_ld_resp_valid"}, ld_resp_valid, 1'b0);
    chk({tag, "_ld_resp_idx"}, ld_resp_idx, '0);
    chk({tag, "_st_done"}, st_done, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ld_req_ready"}, ld_req_ready, 1'b0);
    chk({tag, "_st_req_ready"}, st_req_ready, 1'b0);
  endtask

  int exp_order[$];

  initial begin
    idle_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_outputs_zero("rst");
    rst_n = 1'b1;
    step();

    // Lone load: capture, issue, respond, back to idle
    ld_req_valid = 1'b1;
    ld_req_addr  = 32'h40;
    ld_req_idx   = 3'd5;
    step();
    ld_req_valid = 1'b0;
    dc_req_ready = 1'b1;
    step();
    dc_req_ready  = 1'b0;
    dc_resp_valid = 1'b1;
    dc_resp_data  = 32'hDEADBEEF;
    #4;
    chk("lone_ld_resp_valid", ld_resp_valid, 1'b1);
    chk("lone_ld_resp_idx", ld_resp_idx, 3'd5);
    chk("lone_ld_resp_data", ld_resp_data, 32'hDEADBEEF);
    #1;
    @(posedge clk);
    model_update(0);
    #1;
    idle_in();
    #4;
    chk("lone_busy_c3", busy, 1'b0);
    @(posedge clk);
    #1;

    // Load and store both pending every cycle
    dut_grants.delete();
    ld_req_valid  = 1'b1;
    st_req_valid  = 1'b1;
    ld_req_addr   = 32'h100;
    st_req_addr   = 32'h200;
    st_req_data   = 32'h5555AAAA;
    dc_req_ready  = 1'b1;
    dc_resp_valid = 1'b1;
    repeat (18) step();
`ifdef DCACHE_ARB_STARVE_GUARD_EN
    exp_order = '{1, 1, 2, 1, 1, 2};
`else
    exp_order = '{1, 1, 1, 1, 1, 1};
`endif
    chk("order_len", dut_grants.size(), 6);
    for (int i = 0; i < 6 && i < dut_grants.size(); i++)
      chk($sformatf("order_%0d", i), dut_grants[i], exp_order[i]);
    dut_grants.delete();
    st_buf_full = 1'b1;
    repeat (3) step();
    chk("full_forces_store_len", dut_grants.size(), 1);
    if (dut_grants.size() > 0)
      chk("full_forces_store", dut_grants[0], 2);
    drain();

    // Store held off by the cache for five cycles
    st_req_valid = 1'b1;
    st_req_addr  = 32'h1234;
    st_req_data  = 32'hCAFEF00D;
    step();
    st_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      st_req_addr = $urandom;
      st_req_data = $urandom;
      step();
    end
    dc_req_ready = 1'b1;
    step();
    dc_req_ready  = 1'b0;
    dc_resp_valid = 1'b1;
    #4;
    chk("stall_st_done", st_done, 1'b1);
    #1;
    @(posedge clk);
    model_update(0);
    #1;
    idle_in();
    step();

    // Flush while a load waits for its response
    ld_req_valid = 1'b1;
    ld_req_addr  = 32'h80;
    ld_req_idx   = 3'd3;
    step();
    ld_req_valid = 1'b0;
    dc_req_ready = 1'b1;
    step();
    dc_req_ready = 1'b0;
    flush        = 1'b1;
    step();
    flush         = 1'b0;
    dc_resp_valid = 1'b1;
    dc_resp_data  = 32'h12345678;
    step();
    dc_resp_valid = 1'b0;
    step();

    // Flush while a load is still waiting for the cache to take it
    ld_req_valid = 1'b1;
    ld_req_addr  = 32'hC0;
    ld_req_idx   = 3'd6;
    step();
    ld_req_valid = 1'b0;
    flush        = 1'b1;
    step();
    flush = 1'b0;
    step();
    dc_resp_valid = 1'b1;
    step();
    dc_resp_valid = 1'b0;

    // Flush during a store's wait does not cancel it
    st_req_valid = 1'b1;
    st_req_addr  = 32'h300;
    st_req_data  = 32'h0BADF00D;
    step();
    st_req_valid = 1'b0;
    dc_req_ready = 1'b1;
    step();
    dc_req_ready = 1'b0;
    flush        = 1'b1;
    step();
    flush         = 1'b0;
    dc_resp_valid = 1'b1;
    step();
    dc_resp_valid = 1'b0;
    step();

    // Reset pulse while a load is in WAIT
    ld_req_valid = 1'b1;
    ld_req_addr  = 32'h440;
    ld_req_idx   = 3'd2;
    step();
    ld_req_valid = 1'b0;
    dc_req_ready = 1'b1;
    step();
    dc_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_outputs_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    dc_resp_valid = 1'b1;
    dc_resp_data  = 32'hFFFF0000;
    step();
    step();
    idle_in();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      ld_req_valid  = ($urandom_range(99) < 60);
      ld_req_addr   = $urandom;
      ld_req_idx    = IW'($urandom);
      st_req_valid  = ($urandom_range(99) < 50);
      st_req_addr   = $urandom;
      st_req_data   = $urandom;
      st_buf_full   = ($urandom_range(99) < 15);
      flush         = ($urandom_range(99) < 10);
      dc_req_ready  = ($urandom_range(99) < 60);
      dc_resp_valid = ($urandom_range(99) < 50);
      dc_resp_data  = $urandom;
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
